// File: rtl/pc_update_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pc_update_sequencer_pkg: shared encodings for the PC-update sequencer slice
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package pc_update_sequencer_pkg;

    localparam logic [2:0] PCSRC_ALU_RESULT = 3'b000;
    localparam logic [2:0] PCSRC_ALU_OUT    = 3'b001;
    localparam logic [2:0] PCSRC_JUMP       = 3'b010;
    localparam logic [2:0] PCSRC_EPC        = 3'b100;
    localparam logic [2:0] PCSRC_LOAD_SIZE  = 3'b110;

    localparam logic [2:0] KIND_SEQ   = 3'b000;
    localparam logic [2:0] KIND_BR_EQ = 3'b001;
    localparam logic [2:0] KIND_BR_NE = 3'b010;
    localparam logic [2:0] KIND_JUMP  = 3'b011;
    localparam logic [2:0] KIND_JR    = 3'b100;
    localparam logic [2:0] KIND_RTE   = 3'b101;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_OPCODE   = 2'b01;
    localparam logic [1:0] CAUSE_OVERFLOW = 2'b10;
    localparam logic [1:0] CAUSE_DIV0     = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_UPDATE    = 3'd1,
        ST_EXC_SAVE  = 3'd2,
        ST_EXC_FETCH = 3'd3,
        ST_EXC_LOAD  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/pc_update_sequencer_exc_priority_encoder.sv
// -----------------------------------------------------------------------------
// exc_priority_encoder: picks the winning exception (opcode > overflow > div0)
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module exc_priority_encoder
    import pc_update_sequencer_pkg::*;
#(
    parameter logic [31:0] VEC_OPCODE = 32'd253,
    parameter logic [31:0] VEC_OVF    = 32'd254,
    parameter logic [31:0] VEC_DIV0   = 32'd255
) (
    input  logic        exc_opcode_i,
    input  logic        exc_overflow_i,
    input  logic        exc_div0_i,
    output logic        valid_o,
    output logic [1:0]  cause_o,
    output logic [31:0] vec_o
);

    always_comb begin
        valid_o = 1'b1;
        cause_o = CAUSE_NONE;
        vec_o   = 32'd0;
        if (exc_opcode_i) begin
            cause_o = CAUSE_OPCODE;
            vec_o   = VEC_OPCODE;
        end else if (exc_overflow_i) begin
            cause_o = CAUSE_OVERFLOW;
            vec_o   = VEC_OVF;
        end else if (exc_div0_i) begin
            cause_o = CAUSE_DIV0;
            vec_o   = VEC_DIV0;
        end else begin
            valid_o = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_update_sequencer.sv
// -----------------------------------------------------------------------------
// pc_update_sequencer: registered PC-write control and exception-entry sequencing
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module pc_update_sequencer
    import pc_update_sequencer_pkg::*;
#(
    parameter int unsigned MEM_LAT    = 2,
    parameter logic [31:0] VEC_OPCODE = 32'd253,
    parameter logic [31:0] VEC_OVF    = 32'd254,
    parameter logic [31:0] VEC_DIV0   = 32'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_req,
    input  logic [2:0]  pc_kind,
    input  logic        alu_zero,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_div0,
    output logic [2:0]  pc_source,
    output logic        pc_write,
    output logic        epc_write,
    output logic        cause_write,
    output logic [1:0]  cause,
    output logic        exc_mem_req,
    output logic [31:0] exc_mem_addr,
    output logic        busy,
    output logic        done,
    output logic        double_fault
);

    localparam logic [2:0] c_lat_m1 = 3'(MEM_LAT - 1);

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [2:0]  pc_source_q;
    logic        pc_write_q;
    logic        epc_write_q;
    logic        cause_write_q;
    logic [1:0]  cause_q;
    logic        exc_mem_req_q;
    logic [31:0] exc_mem_addr_q;
    logic        busy_q;
    logic        done_q;
    logic        double_fault_q;

    logic        w_exc_valid;
    logic [1:0]  w_exc_cause;
    logic [31:0] w_exc_vec;
    logic [2:0]  upd_src_d;
    logic        upd_wr_d;

    exc_priority_encoder #(
        .VEC_OPCODE (VEC_OPCODE),
        .VEC_OVF    (VEC_OVF),
        .VEC_DIV0   (VEC_DIV0)
    ) u_exc_priority_encoder (
        .exc_opcode_i   (exc_opcode),
        .exc_overflow_i (exc_overflow),
        .exc_div0_i     (exc_div0),
        .valid_o        (w_exc_valid),
        .cause_o        (w_exc_cause),
        .vec_o          (w_exc_vec)
    );

    // Reserved kinds keep the previous mux select and suppress the write.
    always_comb begin
        upd_src_d = pc_source_q;
        upd_wr_d  = 1'b0;
        case (pc_kind)
            KIND_SEQ:   begin upd_src_d = PCSRC_ALU_RESULT; upd_wr_d = 1'b1;      end
            KIND_BR_EQ: begin upd_src_d = PCSRC_ALU_OUT;    upd_wr_d = alu_zero;  end
            KIND_BR_NE: begin upd_src_d = PCSRC_ALU_OUT;    upd_wr_d = !alu_zero; end
            KIND_JUMP:  begin upd_src_d = PCSRC_JUMP;       upd_wr_d = 1'b1;      end
            KIND_JR:    begin upd_src_d = PCSRC_ALU_RESULT; upd_wr_d = 1'b1;      end
            KIND_RTE:   begin upd_src_d = PCSRC_EPC;        upd_wr_d = 1'b1;      end
            default:    begin upd_src_d = pc_source_q;      upd_wr_d = 1'b0;      end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 3'd0;
            pc_source_q    <= PCSRC_ALU_RESULT;
            pc_write_q     <= 1'b0;
            epc_write_q    <= 1'b0;
            cause_write_q  <= 1'b0;
            cause_q        <= CAUSE_NONE;
            exc_mem_req_q  <= 1'b0;
            exc_mem_addr_q <= 32'd0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            double_fault_q <= 1'b0;
        end else begin
            pc_write_q    <= 1'b0;
            epc_write_q   <= 1'b0;
            cause_write_q <= 1'b0;
            done_q        <= 1'b0;

            // A new exception during entry is only flagged; the running entry continues.
            if ((state_q == ST_EXC_SAVE || state_q == ST_EXC_FETCH ||
                 state_q == ST_EXC_LOAD) && w_exc_valid) begin
                double_fault_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (w_exc_valid) begin
                        state_q        <= ST_EXC_SAVE;
                        busy_q         <= 1'b1;
                        epc_write_q    <= 1'b1;
                        cause_write_q  <= 1'b1;
                        cause_q        <= w_exc_cause;
                        exc_mem_req_q  <= 1'b1;
                        exc_mem_addr_q <= w_exc_vec;
                    end else if (pc_req) begin
                        state_q     <= ST_UPDATE;
                        busy_q      <= 1'b1;
                        pc_source_q <= upd_src_d;
                        pc_write_q  <= upd_wr_d;
                        done_q      <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                ST_EXC_SAVE: begin
                    state_q <= ST_EXC_FETCH;
                    cnt_q   <= c_lat_m1;
                end
                ST_EXC_FETCH: begin
                    if (cnt_q == 3'd0) begin
                        state_q     <= ST_EXC_LOAD;
                        pc_source_q <= PCSRC_LOAD_SIZE;
                        pc_write_q  <= 1'b1;
                        done_q      <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                ST_EXC_LOAD: begin
                    state_q       <= ST_IDLE;
                    busy_q        <= 1'b0;
                    exc_mem_req_q <= 1'b0;
                end
                default: begin
                    state_q       <= ST_IDLE;
                    busy_q        <= 1'b0;
                    exc_mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc_source    = pc_source_q;
    assign pc_write     = pc_write_q;
    assign epc_write    = epc_write_q;
    assign cause_write  = cause_write_q;
    assign cause        = cause_q;
    assign exc_mem_req  = exc_mem_req_q;
    assign exc_mem_addr = exc_mem_addr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign double_fault = double_fault_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_update_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_update_sequencer: directed scoreboard bench for pc_update_sequencer
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_pc_update_sequencer;

    localparam int MEM_LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pc_req = 1'b0;
    logic [2:0]  pc_kind = 3'b000;
    logic        alu_zero = 1'b0;
    logic        exc_opcode = 1'b0;
    logic        exc_overflow = 1'b0;
    logic        exc_div0 = 1'b0;
    logic [2:0]  pc_source;
    logic        pc_write;
    logic        epc_write;
    logic        cause_write;
    logic [1:0]  cause;
    logic        exc_mem_req;
    logic [31:0] exc_mem_addr;
    logic        busy;
    logic        done;
    logic        double_fault;

    pc_update_sequencer #(
        .MEM_LAT    (MEM_LAT),
        .VEC_OPCODE (32'd253),
        .VEC_OVF    (32'd254),
        .VEC_DIV0   (32'd255)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_req       (pc_req),
        .pc_kind      (pc_kind),
        .alu_zero     (alu_zero),
        .exc_opcode   (exc_opcode),
        .exc_overflow (exc_overflow),
        .exc_div0     (exc_div0),
        .pc_source    (pc_source),
        .pc_write     (pc_write),
        .epc_write    (epc_write),
        .cause_write  (cause_write),
        .cause        (cause),
        .exc_mem_req  (exc_mem_req),
        .exc_mem_addr (exc_mem_addr),
        .busy         (busy),
        .done         (done),
        .double_fault (double_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  src;
        logic        wr;
        logic        exc;
        logic [1:0]  cause;
        logic [31:0] addr;
        int          lat;
    } exp_t;

    exp_t       sb[$];
    logic [2:0] model_src = 3'b000;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one request (called just after an active edge); the next edge samples it.
    task automatic issue(input string name, input logic req, input logic [2:0] kind,
                         input logic zero, input logic eo, input logic ev, input logic ed);
        exp_t e;
        pc_req       = req;
        pc_kind      = kind;
        alu_zero     = zero;
        exc_opcode   = eo;
        exc_overflow = ev;
        exc_div0     = ed;
        e.name  = name;
        e.exc   = eo | ev | ed;
        e.cause = 2'b00;
        e.addr  = 32'd0;
        if (e.exc) begin
            e.src   = 3'b110;
            e.wr    = 1'b1;
            e.lat   = MEM_LAT + 2;
            e.cause = eo ? 2'b01 : (ev ? 2'b10 : 2'b11);
            e.addr  = eo ? 32'd253 : (ev ? 32'd254 : 32'd255);
        end else begin
            e.lat = 1;
            case (kind)
                3'b000:  begin e.src = 3'b000;    e.wr = 1'b1;  end
                3'b001:  begin e.src = 3'b001;    e.wr = zero;  end
                3'b010:  begin e.src = 3'b001;    e.wr = !zero; end
                3'b011:  begin e.src = 3'b010;    e.wr = 1'b1;  end
                3'b100:  begin e.src = 3'b000;    e.wr = 1'b1;  end
                3'b101:  begin e.src = 3'b100;    e.wr = 1'b1;  end
                default: begin e.src = model_src; e.wr = 1'b0;  end
            endcase
        end
        model_src = e.src;
        sb.push_back(e);
    endtask

    // Wait (bounded) for done, then pop the oldest expectation and compare.
    task automatic collect(input int inject);
        exp_t e;
        int   lat;
        int   writes;
        bit   got;
        e      = sb[0];
        lat    = 0;
        writes = 0;
        got    = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            pc_req       = 1'b0;
            exc_opcode   = 1'b0;
            exc_overflow = 1'b0;
            exc_div0     = 1'b0;
            if (i == inject) exc_div0 = 1'b1;
            if (pc_write) writes++;
            if (e.exc && i == 1)
                check({e.name, "_save_strobes"}, {29'd0, epc_write, cause_write, exc_mem_req}, 32'd7);
            if (done) begin
                lat = i;
                got = 1'b1;
                break;
            end
        end
        e = sb.pop_front();
        checks++;
        assert (got) else begin
            errors++;
            $error("FAIL %s_timeout: observed=no_done expected=done", e.name);
        end
        if (got) begin
            check({e.name, "_latency"}, lat, e.lat);
            check({e.name, "_pc_source"}, {29'd0, pc_source}, {29'd0, e.src});
            check({e.name, "_pc_write_pulses"}, writes, e.wr ? 1 : 0);
            if (e.exc) begin
                check({e.name, "_cause"}, {30'd0, cause}, {30'd0, e.cause});
                check({e.name, "_vec_addr"}, exc_mem_addr, e.addr);
                check({e.name, "_mem_req"}, {31'd0, exc_mem_req}, 32'd1);
            end
        end
        exc_div0 = 1'b0;
        @(posedge clk);
        #1;
        check({e.name, "_pulse_end"}, {28'd0, done, pc_write, busy, exc_mem_req}, 32'd0);
    endtask

    initial begin
        #1 reset = 1'b0;
        #1;
        check("reset_outputs", {19'd0, pc_source, pc_write, epc_write, cause_write, cause,
                                exc_mem_req, busy, done, double_fault}, 32'd0);
        check("reset_addr", exc_mem_addr, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Abort an exception entry partway through its fetch wait.
        exc_overflow = 1'b1;
        @(posedge clk); #1;
        exc_overflow = 1'b0;
        @(posedge clk); #1;
        check("mid_fetch_busy", {30'd0, busy, exc_mem_req}, 32'd3);
        #2 reset = 1'b0;
        #1;
        check("async_reset_outputs", {19'd0, pc_source, pc_write, epc_write, cause_write, cause,
                                      exc_mem_req, busy, done, double_fault}, 32'd0);
        check("async_reset_addr", exc_mem_addr, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        model_src = 3'b000;
        @(posedge clk); #1;
        check("post_reset_idle", {31'd0, busy}, 32'd0);

        issue("seq", 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);       collect(0);
        issue("beq_nt", 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);    collect(0);
        issue("beq_t", 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);     collect(0);
        issue("bne_t", 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);     collect(0);
        issue("bne_nt", 1'b1, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0);    collect(0);
        issue("jump", 1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0);      collect(0);
        issue("jr", 1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);        collect(0);
        issue("rte", 1'b1, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0);       collect(0);
        issue("reserved6", 1'b1, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0); collect(0);
        issue("reserved7", 1'b1, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0); collect(0);
        check("no_double_fault_yet", {31'd0, double_fault}, 32'd0);

        issue("ovf_div0", 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);  collect(0);
        issue("opc_jump", 1'b1, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0);  collect(0);
        check("still_no_double_fault", {31'd0, double_fault}, 32'd0);

        issue("ovf_nested", 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0); collect(2);
        check("double_fault_set", {31'd0, double_fault}, 32'd1);
        issue("seq_after_df", 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0); collect(0);
        check("double_fault_sticky", {31'd0, double_fault}, 32'd1);
        issue("div0", 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);      collect(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_update_sequencer.md
Name: pc_update_sequencer

Overview:
- Multicycle PC controller.
- Turns one-cycle PC-update requests from the main control FSM into registered pc_source/pc_write pulses for the PC-source mux.
- Sequences the full exception entry: EPC save, cause latch, vector-byte fetch, then PC load through the load_size path.
- Sits between the main control unit, the PC register and the memory address mux.

Parameters:
- MEM_LAT, 2, cycles from exc_mem_req until the vector byte is valid on the load_size path (1..7)
- VEC_OPCODE, 32'd253, memory address of the invalid-opcode handler byte
- VEC_OVF, 32'd254, memory address of the overflow handler byte
- VEC_DIV0, 32'd255, memory address of the divide-by-zero handler byte

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- pc_req  in  1  one-cycle request to update the PC; sampled only in IDLE
- pc_kind  in  3  SEQ=000, BR_EQ=001, BR_NE=010, JUMP=011, JR=100, RTE=101; 110 and 111 reserved
- alu_zero  in  1  ALU zero flag, sampled with pc_req
- exc_opcode  in  1  invalid-opcode exception request
- exc_overflow  in  1  overflow exception request
- exc_div0  in  1  divide-by-zero exception request
- pc_source  out  3  mux select: 000 alu_result, 001 alu_out, 010 jump, 100 epc, 110 load_size
- pc_write  out  1  PC register write enable
- epc_write  out  1  EPC register write enable
- cause_write  out  1  cause register write enable
- cause  out  2  01 opcode, 10 overflow, 11 div0
- exc_mem_req  out  1  forces the memory address mux to exc_mem_addr
- exc_mem_addr  out  32  vector-byte address
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on the cycle the final PC write is issued
- double_fault  out  1  sticky flag; cleared only by reset

Behaviour:
- All outputs are registered. While reset is low: state=IDLE and every output is 0 (pc_source=000, exc_mem_addr=0, double_fault=0).
- Reset asserted mid-sequence aborts immediately to IDLE. No partial write is completed.
- States: IDLE, UPDATE, EXC_SAVE, EXC_FETCH, EXC_LOAD.
- Sampling happens only in IDLE. Priority: any exc_* input over pc_req.
- Exception priority when several are high together: opcode > overflow > div0. Only the winner is latched.
- Normal path: pc_req sampled at edge N → UPDATE during cycle N+1, with pc_write=1 and done=1 for exactly one cycle → IDLE.
- pc_source per pc_kind:
  - SEQ → 000, JR → 000, JUMP → 010, RTE → 100.
  - BR_EQ → 001; pc_write=alu_zero.
  - BR_NE → 001; pc_write=!alu_zero.
  - done pulses even when a branch is not taken.
- Reserved pc_kind: UPDATE is still entered, with pc_write=0 and done=1.
- Exception path, sampled at edge N:
  - EXC_SAVE in cycle N+1: epc_write=1, cause_write=1, cause=code, exc_mem_req=1, exc_mem_addr=vector.
  - EXC_FETCH for MEM_LAT cycles. exc_mem_req stays 1 and the address is held. A 3-bit down-counter loads MEM_LAT-1 and exits at 0.
  - EXC_LOAD: pc_source=110, pc_write=1, done=1, exc_mem_req=1 → IDLE.
  - Total latency is MEM_LAT+2 cycles after the sampling edge.
- pc_source holds its last value in IDLE. pc_write, epc_write, cause_write and done are single-cycle pulses.
- cause holds its value until the next exception.
- Any exc_* high while in EXC_SAVE, EXC_FETCH or EXC_LOAD sets double_fault. The sequence continues unchanged.
- pc_req while busy is ignored. The control FSM must wait for done.
- exc_* high during UPDATE is ignored by this block.

Decomposition:
- Shared package holds:
  - pc_source encodings (PCSRC_ALU_RESULT, PCSRC_ALU_OUT, PCSRC_JUMP, PCSRC_EPC, PCSRC_LOAD_SIZE)
  - pc_kind encodings
  - cause codes
  - state encoding
- One sub-module, exc_priority_encoder: combinational; maps the three exc_* inputs to a valid flag, the cause code and the vector address.

Test Plan:
- Reset low mid-EXC_FETCH → all outputs 0 asynchronously, with no waiting for a clock edge. After release, pc_req SEQ → pc_write=1, pc_source=000 one cycle later.
- pc_req BR_EQ with alu_zero=0 → pc_source=001, pc_write=0, done=1. Repeat with alu_zero=1 → pc_write=1.
- JUMP, then JR, then RTE back-to-back (each issued after done) → pc_source=010, then 000, then 100, each with one pc_write pulse.
- exc_overflow and exc_div0 in the same cycle, MEM_LAT=2 → cause=10, exc_mem_addr=254. done plus pc_source=110 arrive 4 cycles after the sampling edge.
- exc_opcode and pc_req JUMP in the same cycle → exception wins: cause=01, exc_mem_addr=253, and no pc_source=010 write occurs.
- exc_div0 asserted during EXC_FETCH → double_fault=1 and stays high. The running sequence still completes with the original cause.
